// File: rtl/lfsr_dir_gen_if.sv
// lfsr_dir_gen_if: seed/direction handshake bundle between BAS controller, generator and consumer
// master: drives load, seed, dir_ready; observes dir_valid, dir, sample_count, cycled
// slave : the generator side
interface lfsr_dir_gen_if #(
  parameter int WIDTH = 9,
  parameter int NCH   = 2,
  parameter int CNT_W = 16
);
  logic                 load;
  logic [NCH*WIDTH-1:0] seed;
  logic                 dir_valid;
  logic                 dir_ready;
  logic [NCH*WIDTH-1:0] dir;
  logic [CNT_W-1:0]     sample_count;
  logic [NCH-1:0]       cycled;
  modport master (output load, seed, dir_ready, input dir_valid, dir, sample_count, cycled);
  modport slave  (input load, seed, dir_ready, output dir_valid, dir, sample_count, cycled);
endinterface

// File: rtl/lfsr_dir_gen.sv
// lfsr_dir_gen: NCH-channel Fibonacci LFSR direction generator with valid/ready output
// i_clock, i_reset (sync, active-high); bus: lfsr_dir_gen_if.slave (load/seed in, dir handshake out,
// sample_count, sticky per-channel cycled). LFSR_DIR_SIGNED_EN: dir is state with MSB inverted.
module lfsr_dir_gen #(
  parameter int          WIDTH = 9,
  parameter int          NCH   = 2,
  parameter int unsigned TAPS  = 9'h110,
  parameter int          STEPS = 1,
  parameter int          CNT_W = 16
) (
  input logic           i_clock,
  input logic           i_reset,
  lfsr_dir_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] TAP_M  = WIDTH'(TAPS);
  localparam logic [7:0]       STEP_N = (STEPS == 0) ? 8'd1 : 8'(STEPS);
  typedef enum logic [1:0] {UNSEEDED, VALID, STEP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr [NCH];
  logic [WIDTH-1:0] r_ref  [NCH];
  logic [WIDTH-1:0] w_next [NCH];
  logic [WIDTH-1:0] w_seed [NCH];
  logic [7:0]       r_left;
  logic [CNT_W-1:0] r_cnt;
  logic [NCH-1:0]   r_cycled;
  logic             r_valid;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // all-zero is the lock-up state, so a zero seed becomes 1
    assign w_seed[g] = (bus.seed[g*WIDTH +: WIDTH] == '0) ? WIDTH'(1) : bus.seed[g*WIDTH +: WIDTH];
    assign w_next[g] = {r_lfsr[g][WIDTH-2:0], ^(r_lfsr[g] & TAP_M)};
`ifdef LFSR_DIR_SIGNED_EN
    assign bus.dir[g*WIDTH +: WIDTH] = {~r_lfsr[g][WIDTH-1], r_lfsr[g][WIDTH-2:0]};
`else
    assign bus.dir[g*WIDTH +: WIDTH] = r_lfsr[g];
`endif
  end
  assign bus.dir_valid    = r_valid;
  assign bus.sample_count = r_cnt;
  assign bus.cycled       = r_cycled;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= UNSEEDED;
      r_left   <= '0;
      r_cnt    <= '0;
      r_cycled <= '0;
      r_valid  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_lfsr[i] <= '0;
        r_ref[i]  <= '0;
      end
    end else if (bus.load) begin
      r_state  <= VALID;
      r_left   <= '0;
      r_cnt    <= '0;
      r_cycled <= '0;
      r_valid  <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        r_lfsr[i] <= w_seed[i];
        r_ref[i]  <= w_seed[i];
      end
    end else if (r_state == VALID && bus.dir_ready) begin
      r_state <= STEP;
      r_valid <= 1'b0;
      r_left  <= STEP_N;
      r_cnt   <= r_cnt + 1'b1;
    end else if (r_state == STEP) begin
      for (int i = 0; i < NCH; i++) begin
        r_lfsr[i] <= w_next[i];
        if (w_next[i] == r_ref[i]) r_cycled[i] <= 1'b1;
      end
      r_left <= r_left - 1'b1;
      if (r_left == 8'd1) begin
        r_state <= VALID;
        r_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_dir_gen.sv
// tb_lfsr_dir_gen: three generators (STEPS 1,3,4) on shared stimulus, position-based reference model
module tb_lfsr_dir_gen;
  localparam int W = 9;
  localparam int N = 2;
  localparam int C = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic ready = 1'b0;
  logic [N*W-1:0] seed = '0;
  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;
  always #5 clk = ~clk;
  lfsr_dir_gen_if #(.WIDTH(W), .NCH(N), .CNT_W(C)) if1 ();
  lfsr_dir_gen_if #(.WIDTH(W), .NCH(N), .CNT_W(C)) if3 ();
  lfsr_dir_gen_if #(.WIDTH(W), .NCH(N), .CNT_W(C)) if4 ();
  assign if1.load = load;
  assign if1.seed = seed;
  assign if1.dir_ready = ready;
  assign if3.load = load;
  assign if3.seed = seed;
  assign if3.dir_ready = ready;
  assign if4.load = load;
  assign if4.seed = seed;
  assign if4.dir_ready = ready;
  lfsr_dir_gen #(.WIDTH(W), .NCH(N), .TAPS(9'h110), .STEPS(1), .CNT_W(C)) u1 (.i_clock(clk), .i_reset(rst), .bus(if1));
  lfsr_dir_gen #(.WIDTH(W), .NCH(N), .TAPS(9'h110), .STEPS(3), .CNT_W(C)) u3 (.i_clock(clk), .i_reset(rst), .bus(if3));
  lfsr_dir_gen #(.WIDTH(W), .NCH(N), .TAPS(9'h110), .STEPS(4), .CNT_W(C)) u4 (.i_clock(clk), .i_reset(rst), .bus(if4));
  logic           dv  [3];
  logic [N*W-1:0] dd  [3];
  logic [C-1:0]   dc  [3];
  logic [N-1:0]   dcy [3];
  assign dv[0] = if1.dir_valid;
  assign dv[1] = if3.dir_valid;
  assign dv[2] = if4.dir_valid;
  assign dd[0] = if1.dir;
  assign dd[1] = if3.dir;
  assign dd[2] = if4.dir;
  assign dc[0] = if1.sample_count;
  assign dc[1] = if3.sample_count;
  assign dc[2] = if4.sample_count;
  assign dcy[0] = if1.cycled;
  assign dcy[1] = if3.cycled;
  assign dcy[2] = if4.cycled;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] td(input int v);
`ifdef LFSR_DIR_SIGNED_EN
    return W'(v) ^ (W'(1) << (W - 1));
`else
    return W'(v);
`endif
  endfunction
  // maximal-length sequence from state 1; any nonzero state is a position in it
  int seq [511];
  int pos [512];
  function automatic int nxt(input int v);
    return ((v << 1) & 511) | int'(^(v & 'h110));
  endfunction
  int steps_of [3] = '{1, 3, 4};
  bit m_seeded [3] = '{0, 0, 0};
  bit m_valid [3] = '{0, 0, 0};
  int m_rem [3] = '{0, 0, 0};
  int m_cnt [3] = '{0, 0, 0};
  int m_sh [3] = '{0, 0, 0};
  int m_p [3][2] = '{'{-1, -1}, '{-1, -1}, '{-1, -1}};
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_seeded[d] = 0; m_valid[d] = 0; m_rem[d] = 0; m_cnt[d] = 0; m_sh[d] = 0;
        m_p[d][0] = -1; m_p[d][1] = -1;
      end else if (load) begin
        for (int c = 0; c < N; c++) begin
          int s;
          s = int'(seed[c*W +: W]);
          m_p[d][c] = pos[(s == 0) ? 1 : s];
        end
        m_seeded[d] = 1; m_valid[d] = 1; m_rem[d] = 0; m_cnt[d] = 0; m_sh[d] = 0;
      end else if (m_seeded[d] && m_valid[d] && ready) begin
        m_cnt[d] = (m_cnt[d] + 1) & 16'hFFFF;
        m_valid[d] = 0;
        m_rem[d] = steps_of[d];
      end else if (m_rem[d] > 0) begin
        for (int c = 0; c < N; c++) m_p[d][c] = (m_p[d][c] + 1) % 511;
        m_sh[d]++;
        m_rem[d]--;
        if (m_rem[d] == 0) m_valid[d] = 1;
      end
    end
  end
  function automatic int raw(input int p);
    return (p < 0) ? 0 : seq[p];
  endfunction
  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("m%0d_valid", d), 64'(dv[d]), 64'(m_valid[d]));
        chk($sformatf("m%0d_dir", d), 64'(dd[d]), 64'({td(raw(m_p[d][1])), td(raw(m_p[d][0]))}));
        chk($sformatf("m%0d_cnt", d), 64'(dc[d]), 64'(m_cnt[d]));
        chk($sformatf("m%0d_cycled", d), 64'(dcy[d]), (m_sh[d] >= 511) ? 64'h3 : 64'h0);
      end
    end
  end
  task automatic cyc(input logic l, input logic [N*W-1:0] s, input logic rd);
    @(negedge clk);
    load = l;
    seed = s;
    ready = rd;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic rs, ld;
    logic [W-1:0] s0, s1;
    logic rd, ev;
    int e0, e1, ec;
  } vec_t;
  vec_t tv [13];
  initial begin
    int v;
    int low;
    v = 1;
    for (int k = 0; k < 511; k++) begin
      seq[k] = v;
      pos[v] = k;
      v = nxt(v);
    end
    pos[0] = 0;
    tv[0]  = '{1, 0, 9'h000, 9'h000, 0, 0, 'h000, 'h000, 0};
    tv[1]  = '{0, 1, 9'h001, 9'h000, 0, 1, 'h001, 'h001, 0};
    tv[2]  = '{0, 0, 9'h000, 9'h000, 1, 0, 'h001, 'h001, 1};
    tv[3]  = '{0, 0, 9'h000, 9'h000, 1, 1, 'h002, 'h002, 1};
    tv[4]  = '{0, 0, 9'h000, 9'h000, 1, 0, 'h002, 'h002, 2};
    tv[5]  = '{0, 0, 9'h000, 9'h000, 1, 1, 'h004, 'h004, 2};
    tv[6]  = '{0, 0, 9'h000, 9'h000, 1, 0, 'h004, 'h004, 3};
    tv[7]  = '{0, 0, 9'h000, 9'h000, 1, 1, 'h008, 'h008, 3};
    tv[8]  = '{0, 0, 9'h000, 9'h000, 1, 0, 'h008, 'h008, 4};
    tv[9]  = '{0, 0, 9'h000, 9'h000, 1, 1, 'h010, 'h010, 4};
    tv[10] = '{0, 0, 9'h000, 9'h000, 1, 0, 'h010, 'h010, 5};
    tv[11] = '{0, 0, 9'h000, 9'h000, 1, 1, 'h021, 'h021, 5};
    tv[12] = '{0, 0, 9'h000, 9'h000, 0, 1, 'h021, 'h021, 5};
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = tv[i].rs;
      load = tv[i].ld;
      seed = {tv[i].s1, tv[i].s0};
      ready = tv[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_valid", i), 64'(dv[0]), 64'(tv[i].ev));
      chk($sformatf("tv%0d_dir", i), 64'(dd[0]), 64'({td(tv[i].e1), td(tv[i].e0)}));
      chk($sformatf("tv%0d_cnt", i), 64'(dc[0]), 64'(tv[i].ec));
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, '0, 0);
      chk("hold_dir", 64'(dd[0]), 64'({td('h021), td('h021)}));
      chk("hold_cnt", 64'(dc[0]), 64'd5);
    end
    cyc(0, '0, 1);
    for (int i = 0; i < 4; i++) cyc(0, '0, 0);
    chk("pulse_cnt", 64'(dc[0]), 64'd6);
    chk("pulse_dir", 64'(dd[0]), 64'({td('h042), td('h042)}));
    cyc(1, {9'h000, 9'h001}, 0);
    cyc(0, '0, 1);
    ready = 1'b0;
    low = 0;
    for (int i = 0; i < 20 && !dv[1]; i++) begin
      low++;
      @(posedge clk);
      #1;
    end
    chk("s3_low_cycles", 64'(low), 64'd3);
    chk("s3_dir", 64'(dd[1][W-1:0]), 64'(td('h008)));
    cyc(1, {9'h000, 9'h001}, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    cyc(1, {9'h155, 9'h0AA}, 0);
    chk("midstep_valid", 64'(dv[2]), 64'd1);
    chk("midstep_dir", 64'(dd[2]), 64'({td('h155), td('h0AA)}));
    chk("midstep_cnt", 64'(dc[2]), 64'd0);
    cyc(1, {9'h000, 9'h111}, 0);
    cyc(1, {9'h000, 9'h033}, 1);
    chk("ldxfer_valid", 64'(dv[0]), 64'd1);
    chk("ldxfer_dir", 64'(dd[0]), 64'({td('h001), td('h033)}));
    chk("ldxfer_cnt", 64'(dc[0]), 64'd0);
    cyc(1, {9'h000, 9'h001}, 0);
    @(negedge clk);
    load = 1'b0;
    ready = 1'b1;
    for (int k = 1; k <= 1022; k++) begin
      @(posedge clk);
      #1;
      if (k == 1021) chk("period_pre", 64'(dcy[0]), 64'd0);
    end
    chk("period_cycled", 64'(dcy[0]), 64'h3);
    chk("period_dir", 64'(dd[0]), 64'({td('h001), td('h001)}));
    chk("period_cnt", 64'(dc[0]), 64'd511);
    cyc(1, {9'h000, 9'h005}, 0);
    chk("period_clear", 64'(dcy[0]), 64'd0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 39) == 0);
      seed = {($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom), ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom)};
      ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    @(posedge clk);
    #1;
    chk("final_reset_valid", 64'(dv[0]), 64'd0);
    chk("final_reset_dir", 64'(dd[0]), 64'({td(0), td(0)}));
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
